// File: rtl/payload_demux.sv
// payload_demux: receive-side demultiplexer placed after the firewall.
// Assembles a dibit stream into bytes, decodes a per-packet channel tag and a
// big-endian base address, then routes payload bytes to one of NUM_CH channels
// with an incrementing address. The last TRAIL_BYTES bytes (the FCS) are held
// back and discarded when the packet ends.
//
// Optional build macro PAYLOAD_DEMUX_STATS_EN adds saturating drop/runt counters.

module payload_demux #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned ADDR_BYTES  = 3,
  parameter int unsigned TRAIL_BYTES = 4,
  localparam int unsigned ADDR_W     = 8 * ADDR_BYTES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              axiiv,
  input  logic [1:0]        axiid,
  output logic              addr_axiov,
  output logic [ADDR_W-1:0] addr,
  output logic [NUM_CH-1:0] data_axiov,
  output logic [7:0]        data,
  output logic [ADDR_W-1:0] data_addr,
  output logic [NUM_CH-1:0] eop_axiov
`ifdef PAYLOAD_DEMUX_STATS_EN
  ,
  output logic [15:0]       drop_count,
  output logic [15:0]       runt_count
`endif
);

  localparam int unsigned ChW       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned HcW       = (ADDR_BYTES > 1) ? $clog2(ADDR_BYTES) : 1;
  // A zero-length trailer still needs a legal array; it is simply never used.
  localparam int unsigned FifoDepth = (TRAIL_BYTES == 0) ? 1 : TRAIL_BYTES;
  localparam int unsigned FillW     = $clog2(FifoDepth + 1);

  typedef enum logic [2:0] {StIdle, StTag, StAddr, StData, StDrop} state_e;

  state_e            state_q;
  logic [1:0]        dibit_cnt_q;
  logic [5:0]        shift_q;
  logic              armed_q;
  logic [ChW-1:0]    ch_q;
  logic [HcW-1:0]    hdr_cnt_q;
  logic [ADDR_W-1:0] hdr_sr_q;
  logic [7:0]        fifo_q [FifoDepth];
  logic [FillW-1:0]  fill_q;
  logic [ADDR_W-1:0] idx_q;
  logic              emitted_q;

  logic              byte_done;
  logic [7:0]        cur_byte;
  logic [ADDR_W-1:0] hdr_next;
  logic              tag_ok;
  logic              fifo_full;
  logic [7:0]        emit_byte;
  logic [NUM_CH-1:0] ch_onehot;
  logic              pkt_end;
  logic              runt_end;

  // Byte-completion decode and datapath helpers
  always_comb begin
    byte_done = axiiv && (dibit_cnt_q == 2'd3);
    cur_byte  = {shift_q, axiid};
    hdr_next  = (hdr_sr_q << 8) | ADDR_W'(cur_byte);
    tag_ok    = ({24'd0, cur_byte} < NUM_CH);
    fifo_full = (TRAIL_BYTES == 0) || (fill_q == FillW'(TRAIL_BYTES));
    emit_byte = (TRAIL_BYTES == 0) ? cur_byte : fifo_q[FifoDepth-1];
    pkt_end   = !axiiv;
    // Packet that produced nothing: died in header or before any byte left the trailer.
    runt_end  = pkt_end && ((state_q == StTag) || (state_q == StAddr) ||
                            ((state_q == StData) && !emitted_q));
    for (int i = 0; i < NUM_CH; i++) begin
      ch_onehot[i] = (ch_q == ChW'(i));
    end
  end

  // Dibit shifter; a low axiiv discards any partial byte
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dibit_cnt_q <= 2'd0;
      shift_q     <= 6'd0;
    end else if (!axiiv) begin
      dibit_cnt_q <= 2'd0;
    end else begin
      dibit_cnt_q <= dibit_cnt_q + 2'd1;
      shift_q     <= {shift_q[3:0], axiid};
    end
  end

  // Packet FSM with registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= StIdle;
      armed_q    <= 1'b0;
      ch_q       <= '0;
      hdr_cnt_q  <= '0;
      hdr_sr_q   <= '0;
      fill_q     <= '0;
      idx_q      <= '0;
      emitted_q  <= 1'b0;
      addr_axiov <= 1'b0;
      addr       <= '0;
      data_axiov <= '0;
      data       <= 8'd0;
      data_addr  <= '0;
      eop_axiov  <= '0;
      for (int i = 0; i < FifoDepth; i++) begin
        fifo_q[i] <= 8'd0;
      end
    end else begin
      addr_axiov <= 1'b0;
      data_axiov <= '0;
      eop_axiov  <= '0;
      if (pkt_end) begin
        // Armed only after a low cycle, so a reset mid-packet ignores the tail.
        armed_q   <= 1'b1;
        if ((state_q == StData) && emitted_q) begin
          eop_axiov <= ch_onehot;
        end
        state_q   <= StIdle;
        fill_q    <= '0;
        idx_q     <= '0;
        emitted_q <= 1'b0;
        hdr_cnt_q <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (armed_q) begin
              state_q <= StTag;
            end
          end
          StTag: begin
            if (byte_done) begin
              ch_q      <= cur_byte[ChW-1:0];
              hdr_cnt_q <= '0;
              state_q   <= tag_ok ? StAddr : StDrop;
            end
          end
          StAddr: begin
            if (byte_done) begin
              hdr_sr_q <= hdr_next;
              if (hdr_cnt_q == HcW'(ADDR_BYTES - 1)) begin
                addr       <= hdr_next;
                addr_axiov <= 1'b1;
                state_q    <= StData;
              end else begin
                hdr_cnt_q <= hdr_cnt_q + 1'b1;
              end
            end
          end
          StData: begin
            if (byte_done) begin
              if (fifo_full) begin
                data       <= emit_byte;
                data_axiov <= ch_onehot;
                data_addr  <= addr + idx_q;
                idx_q      <= idx_q + 1'b1;
                emitted_q  <= 1'b1;
              end
              if (TRAIL_BYTES != 0) begin
                // Shift register: newest at [0], oldest at [FifoDepth-1] once full.
                fifo_q[0] <= cur_byte;
                for (int i = 1; i < FifoDepth; i++) begin
                  fifo_q[i] <= fifo_q[i-1];
                end
                if (!fifo_full) begin
                  fill_q <= fill_q + 1'b1;
                end
              end
            end
          end
          StDrop: begin
            state_q <= StDrop;
          end
          default: begin
            state_q <= StIdle;
          end
        endcase
      end
    end
  end

`ifdef PAYLOAD_DEMUX_STATS_EN
  logic drop_evt;

  // Drop event: tag byte completes with an out-of-range channel
  always_comb begin
    drop_evt = axiiv && (state_q == StTag) && byte_done && !tag_ok;
  end

  // Saturating packet statistics
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_count <= 16'd0;
      runt_count <= 16'd0;
    end else begin
      if (drop_evt && (drop_count != 16'hFFFF)) begin
        drop_count <= drop_count + 16'd1;
      end
      if (runt_end && (runt_count != 16'hFFFF)) begin
        runt_count <= runt_count + 16'd1;
      end
    end
  end
`else
  logic unused_runt;

  // Runt decode only feeds the statistics counters
  always_comb begin
    unused_runt = runt_end;
  end
`endif

endmodule

// File: tb/tb_payload_demux.sv
// Directed bench for payload_demux (NUM_CH=2, ADDR_BYTES=3, TRAIL_BYTES=4).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_payload_demux;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        axiiv = 1'b0;
  logic [1:0]  axiid = 2'd0;
  logic        addr_axiov;
  logic [23:0] addr;
  logic [1:0]  data_axiov;
  logic [7:0]  data;
  logic [23:0] data_addr;
  logic [1:0]  eop_axiov;
`ifdef PAYLOAD_DEMUX_STATS_EN
  logic [15:0] drop_count;
  logic [15:0] runt_count;
`endif

  int checks = 0;
  int errors = 0;
  int onehot_bad = 0;

  logic [23:0] addr_log [$];
  logic [33:0] data_log [$];
  logic [1:0]  eop_log  [$];
  logic [7:0]  pkt      [$];

  always #5 clk = ~clk;

  payload_demux #(
    .NUM_CH      (2),
    .ADDR_BYTES  (3),
    .TRAIL_BYTES (4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .axiiv      (axiiv),
    .axiid      (axiid),
    .addr_axiov (addr_axiov),
    .addr       (addr),
    .data_axiov (data_axiov),
    .data       (data),
    .data_addr  (data_addr),
    .eop_axiov  (eop_axiov)
`ifdef PAYLOAD_DEMUX_STATS_EN
    ,
    .drop_count (drop_count),
    .runt_count (runt_count)
`endif
  );

  // Passive event recorder
  always @(negedge clk) begin
    if (addr_axiov === 1'b1) addr_log.push_back(addr);
    if (data_axiov !== 2'b00) data_log.push_back({data_axiov, data, data_addr});
    if (eop_axiov !== 2'b00) eop_log.push_back(eop_axiov);
    if ((data_axiov === 2'b11) || (eop_axiov === 2'b11) ||
        ((data_axiov !== 2'b00) && (eop_axiov !== 2'b00))) onehot_bad++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [33:0] data_at(input int i);
    return (i < data_log.size()) ? data_log[i] : '1;
  endfunction

  function automatic logic [23:0] addr_at(input int i);
    return (i < addr_log.size()) ? addr_log[i] : '1;
  endfunction

  function automatic logic [1:0] eop_at(input int i);
    return (i < eop_log.size()) ? eop_log[i] : 2'b00;
  endfunction

  task automatic clear_logs();
    addr_log.delete();
    data_log.delete();
    eop_log.delete();
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) begin
      axiiv = 1'b1;
      axiid = b[7-2*i -: 2];
      @(negedge clk);
    end
  endtask

  task automatic send_pkt();
    foreach (pkt[i]) send_byte(pkt[i]);
  endtask

  task automatic idle(input int n);
    axiiv = 1'b0;
    axiid = 2'd0;
    repeat (n) @(negedge clk);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, " addr_axiov"}, 64'(addr_axiov), 64'd0);
    check({tag, " addr"},       64'(addr),       64'd0);
    check({tag, " data_axiov"}, 64'(data_axiov), 64'd0);
    check({tag, " data"},       64'(data),       64'd0);
    check({tag, " data_addr"},  64'(data_addr),  64'd0);
    check({tag, " eop_axiov"},  64'(eop_axiov),  64'd0);
  endtask

  initial begin
    // Reset state
    rst = 1'b0;
    idle(2);
    check_outputs_zero("reset");
`ifdef PAYLOAD_DEMUX_STATS_EN
    check("reset drop_count", 64'(drop_count), 64'd0);
    check("reset runt_count", 64'(runt_count), 64'd0);
`endif
    rst = 1'b1;
    idle(2);

    // Nominal packet on channel 1
    clear_logs();
    pkt = '{8'h01, 8'h00, 8'h12, 8'h34, 8'hAA, 8'hBB, 8'hCC, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_pkt();
    idle(1);
    check("nom eop", 64'(eop_axiov), 64'(2'b10));
    idle(2);
    check("nom addr pulses", 64'(addr_log.size()), 64'd1);
    check("nom addr val",    64'(addr_at(0)),      64'h001234);
    check("nom addr held",   64'(addr),            64'h001234);
    check("nom data count",  64'(data_log.size()), 64'd3);
    check("nom data0", 64'(data_at(0)), 64'({2'b10, 8'hAA, 24'h001234}));
    check("nom data1", 64'(data_at(1)), 64'({2'b10, 8'hBB, 24'h001235}));
    check("nom data2", 64'(data_at(2)), 64'({2'b10, 8'hCC, 24'h001236}));
    check("nom eop count", 64'(eop_log.size()), 64'd1);

    // Invalid tag is dropped silently
    clear_logs();
    pkt = '{8'h05, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    send_pkt();
    idle(3);
    check("drop addr pulses", 64'(addr_log.size()), 64'd0);
    check("drop data count",  64'(data_log.size()), 64'd0);
    check("drop eop count",   64'(eop_log.size()),  64'd0);
    check("drop addr held",   64'(addr),            64'h001234);
`ifdef PAYLOAD_DEMUX_STATS_EN
    check("drop drop_count", 64'(drop_count), 64'd1);
`endif

    // Address wrap: three payload bytes plus four trailer bytes on channel 0
    clear_logs();
    pkt = '{8'h00, 8'hFF, 8'hFF, 8'hFE, 8'h10, 8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
    send_pkt();
    idle(1);
    check("wrap eop", 64'(eop_axiov), 64'(2'b01));
    idle(2);
    check("wrap addr val",   64'(addr_at(0)),      64'hFFFFFE);
    check("wrap data count", 64'(data_log.size()), 64'd3);
    check("wrap data0", 64'(data_at(0)), 64'({2'b01, 8'h10, 24'hFFFFFE}));
    check("wrap data1", 64'(data_at(1)), 64'({2'b01, 8'h11, 24'hFFFFFF}));
    check("wrap data2", 64'(data_at(2)), 64'({2'b01, 8'h12, 24'h000000}));

    // Mid-byte truncation: two whole payload bytes then half a byte
    clear_logs();
    pkt = '{8'h01, 8'h00, 8'h00, 8'h10, 8'h01, 8'h02};
    send_pkt();
    axiiv = 1'b1; axiid = 2'b11; @(negedge clk);
    axiiv = 1'b1; axiid = 2'b01; @(negedge clk);
    idle(1);
    check("trunc eop", 64'(eop_axiov), 64'd0);
    idle(2);
    check("trunc addr pulses", 64'(addr_log.size()), 64'd1);
    check("trunc data count",  64'(data_log.size()), 64'd0);
    check("trunc eop count",   64'(eop_log.size()),  64'd0);
`ifdef PAYLOAD_DEMUX_STATS_EN
    check("trunc runt_count", 64'(runt_count), 64'd1);
`endif

    // Reset asserted while in DATA, released with axiiv still high
    clear_logs();
    pkt = '{8'h00, 8'h00, 8'h00, 8'h40, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26};
    send_pkt();
    axiiv = 1'b1; axiid = 2'b10; @(negedge clk);
    axiiv = 1'b1; axiid = 2'b01; @(negedge clk);
    check("prerst data count", 64'(data_log.size()), 64'd2);
    check("prerst data0", 64'(data_at(0)), 64'({2'b01, 8'h21, 24'h000040}));
    check("prerst data1", 64'(data_at(1)), 64'({2'b01, 8'h22, 24'h000041}));
    rst = 1'b0;
    #1;
    check_outputs_zero("midrst");
    clear_logs();
    axiiv = 1'b1; axiid = 2'b00; @(negedge clk);
    axiiv = 1'b1; axiid = 2'b11; @(negedge clk);
    rst = 1'b1;
    pkt = '{8'h00, 8'h00, 8'h00, 8'h50, 8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36};
    send_pkt();
    idle(3);
    check("postrst addr pulses", 64'(addr_log.size()), 64'd0);
    check("postrst data count",  64'(data_log.size()), 64'd0);
    check("postrst eop count",   64'(eop_log.size()),  64'd0);
    pkt = '{8'h01, 8'h00, 8'h00, 8'h60, 8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hC4};
    send_pkt();
    idle(1);
    check("clean eop", 64'(eop_axiov), 64'(2'b10));
    idle(2);
    check("clean addr val",   64'(addr_at(0)),      64'h000060);
    check("clean data count", 64'(data_log.size()), 64'd1);
    check("clean data0", 64'(data_at(0)), 64'({2'b10, 8'hC0, 24'h000060}));

    // Back-to-back packets separated by one low cycle
    clear_logs();
    pkt = '{8'h00, 8'h00, 8'h01, 8'h00, 8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5};
    send_pkt();
    idle(1);
    check("b2b eop0", 64'(eop_axiov), 64'(2'b01));
    pkt = '{8'h01, 8'h00, 8'h02, 8'h00, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'hB4};
    send_pkt();
    idle(1);
    check("b2b eop1", 64'(eop_axiov), 64'(2'b10));
    idle(2);
    check("b2b addr pulses", 64'(addr_log.size()), 64'd2);
    check("b2b addr0", 64'(addr_at(0)), 64'h000100);
    check("b2b addr1", 64'(addr_at(1)), 64'h000200);
    check("b2b data count", 64'(data_log.size()), 64'd3);
    check("b2b data0", 64'(data_at(0)), 64'({2'b01, 8'hA0, 24'h000100}));
    check("b2b data1", 64'(data_at(1)), 64'({2'b01, 8'hA1, 24'h000101}));
    check("b2b data2", 64'(data_at(2)), 64'({2'b10, 8'hB0, 24'h000200}));
    check("b2b eop count", 64'(eop_log.size()), 64'd2);
    check("b2b eop order0", 64'(eop_at(0)), 64'(2'b01));
    check("b2b eop order1", 64'(eop_at(1)), 64'(2'b10));

    check("onehot violations", 64'(onehot_bad), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
